// File: rtl/maze_session_ctrl.sv
// Maze game session controller: maze generation handshake, timed rounds, lives, level count.
// Optional MAZE_SESSION_DIFFICULTY_EN shortens the round limit as more mazes are completed.
module maze_session_ctrl #(
    parameter int unsigned COUNT_WIDTH = 8,
    parameter int unsigned TIME_WIDTH  = 12,
    parameter int unsigned ROUND_TIME  = 600,
    parameter int unsigned TIME_STEP   = 50,
    parameter int unsigned MIN_TIME    = 100,
    parameter int unsigned LIVES       = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   tick,
    input  logic                   gen_end,
    input  logic                   player_at_end,
    output logic                   gen_start,
    output logic                   reset_player,
    output logic [TIME_WIDTH-1:0]  time_left,
    output logic [3:0]             lives_left,
    output logic [COUNT_WIDTH-1:0] mazes_complete,
    output logic                   game_over,
    output logic [2:0]             state
);

    localparam int unsigned LIVES_W = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GEN  = 3'd1,
        PLAY = 3'd2,
        DONE = 3'd3,
        OVER = 3'd4
    } state_t;

    state_t                 state_r;
    logic                   gen_end_q;
    logic                   at_end_q;
    logic                   gen_rise_c;
    logic                   at_end_rise_c;
    logic                   timeout_c;
    logic [TIME_WIDTH-1:0]  round_limit_c;

    assign gen_rise_c    = gen_end & ~gen_end_q;
    assign at_end_rise_c = player_at_end & ~at_end_q;
    assign timeout_c     = tick & (time_left == TIME_WIDTH'(1));
    assign state         = state_r;

`ifdef MAZE_SESSION_DIFFICULTY_EN
    // Wide product so large level counts never wrap below the floor.
    localparam int unsigned PROD_W = COUNT_WIDTH + 32;
    localparam logic [PROD_W-1:0] SPAN = PROD_W'(ROUND_TIME - MIN_TIME);

    logic [PROD_W-1:0] step_total_c;

    always_comb begin
        step_total_c  = PROD_W'(mazes_complete) * PROD_W'(TIME_STEP);
        round_limit_c = TIME_WIDTH'(MIN_TIME);
        if (step_total_c < SPAN) begin
            round_limit_c = TIME_WIDTH'(PROD_W'(ROUND_TIME) - step_total_c);
        end
    end
`else
    logic unused_cfg_c;

    assign round_limit_c = TIME_WIDTH'(ROUND_TIME);
    assign unused_cfg_c  = ^{32'(TIME_STEP), 32'(MIN_TIME)};
`endif

    // Session sequencer; every output is a register updated here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            gen_start      <= 1'b0;
            reset_player   <= 1'b1;
            time_left      <= TIME_WIDTH'(ROUND_TIME);
            lives_left     <= LIVES_W'(LIVES);
            mazes_complete <= '0;
            game_over      <= 1'b0;
            gen_end_q      <= 1'b0;
            at_end_q       <= 1'b0;
        end else begin
            gen_end_q <= gen_end;
            at_end_q  <= player_at_end;
            gen_start <= 1'b0;
            case (state_r)
                IDLE, OVER: begin
                    if (start) begin
                        state_r        <= GEN;
                        gen_start      <= 1'b1;
                        reset_player   <= 1'b1;
                        mazes_complete <= '0;
                        lives_left     <= LIVES_W'(LIVES);
                        game_over      <= 1'b0;
                    end
                end
                GEN: begin
                    reset_player <= 1'b1;
                    if (gen_rise_c) begin
                        state_r      <= PLAY;
                        time_left    <= round_limit_c;
                        reset_player <= 1'b0;
                    end
                end
                PLAY: begin
                    reset_player <= 1'b0;
                    if (tick && (time_left != '0)) begin
                        time_left <= time_left - TIME_WIDTH'(1);
                    end
                    // Reaching the exit takes priority over a same-cycle timeout.
                    if (at_end_rise_c) begin
                        state_r      <= DONE;
                        reset_player <= 1'b1;
                        if (mazes_complete != '1) begin
                            mazes_complete <= mazes_complete + COUNT_WIDTH'(1);
                        end
                    end else if (timeout_c) begin
                        reset_player <= 1'b1;
                        if (lives_left > LIVES_W'(1)) begin
                            lives_left <= lives_left - LIVES_W'(1);
                            time_left  <= round_limit_c;
                        end else begin
                            lives_left <= '0;
                            time_left  <= '0;
                            game_over  <= 1'b1;
                            state_r    <= OVER;
                        end
                    end
                end
                DONE: begin
                    state_r      <= GEN;
                    gen_start    <= 1'b1;
                    reset_player <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maze_session_ctrl.sv
// Directed bench for maze_session_ctrl: a default-size instance and a short-round,
// two-life, two-bit-count instance, each checked against hand-computed values.
module tb_maze_session_ctrl;

    logic        clock;
    logic        reset;

    logic        start, tick, gen_end, player_at_end;
    logic        gen_start, reset_player, game_over;
    logic [11:0] time_left;
    logic [3:0]  lives_left;
    logic [7:0]  mazes_complete;
    logic [2:0]  state;

    logic        s_start, s_tick, s_gen_end, s_at_end;
    logic        s_gen_start, s_reset_player, s_game_over;
    logic [11:0] s_time_left;
    logic [3:0]  s_lives_left;
    logic [1:0]  s_mazes_complete;
    logic [2:0]  s_state;

    int n_checks = 0;
    int n_fail   = 0;

    maze_session_ctrl dut (
        .clock(clock), .reset(reset), .start(start), .tick(tick),
        .gen_end(gen_end), .player_at_end(player_at_end),
        .gen_start(gen_start), .reset_player(reset_player), .time_left(time_left),
        .lives_left(lives_left), .mazes_complete(mazes_complete),
        .game_over(game_over), .state(state)
    );

    maze_session_ctrl #(
        .COUNT_WIDTH(2), .TIME_WIDTH(12), .ROUND_TIME(4),
        .TIME_STEP(1), .MIN_TIME(1), .LIVES(2)
    ) dut_s (
        .clock(clock), .reset(reset), .start(s_start), .tick(s_tick),
        .gen_end(s_gen_end), .player_at_end(s_at_end),
        .gen_start(s_gen_start), .reset_player(s_reset_player), .time_left(s_time_left),
        .lives_left(s_lives_left), .mazes_complete(s_mazes_complete),
        .game_over(s_game_over), .state(s_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int lim(input int rt, input int step, input int mn, input int m);
`ifdef MAZE_SESSION_DIFFICULTY_EN
        int v;
        v = rt - m * step;
        return (v < mn) ? mn : v;
`else
        return rt + 0 * (step + mn + m);
`endif
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp_v);
        n_checks++;
        assert (obs === 32'(exp_v))
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic big_complete();
        player_at_end = 1'b1; cyc(1);
        player_at_end = 1'b0; cyc(1);
        gen_end = 1'b0;       cyc(1);
        gen_end = 1'b1;       cyc(1);
    endtask

    task automatic small_complete();
        s_at_end = 1'b1;  cyc(1);
        s_at_end = 1'b0;  cyc(1);
        s_gen_end = 1'b0; cyc(1);
        s_gen_end = 1'b1; cyc(1);
    endtask

    initial begin
        start = 0; tick = 0; gen_end = 0; player_at_end = 0;
        s_start = 0; s_tick = 0; s_gen_end = 0; s_at_end = 0;
        reset = 1'b0;
        #12;
        chk("rst_state", 32'(state), 0);
        chk("rst_gen_start", 32'(gen_start), 0);
        chk("rst_reset_player", 32'(reset_player), 1);
        chk("rst_time_left", 32'(time_left), 600);
        chk("rst_lives", 32'(lives_left), 3);
        chk("rst_mazes", 32'(mazes_complete), 0);
        chk("rst_game_over", 32'(game_over), 0);
        reset = 1'b1;
        cyc(2);

        // Tick in IDLE does nothing.
        tick = 1'b1; cyc(2); tick = 1'b0;
        chk("idle_tick_ignored", 32'(time_left), 600);

        start = 1'b1; cyc(1); start = 1'b0;
        chk("start_state_gen", 32'(state), 1);
        chk("start_gen_start", 32'(gen_start), 1);
        cyc(1);
        chk("gen_start_one_cycle", 32'(gen_start), 0);
        chk("gen_waits", 32'(state), 1);

        cyc(3); gen_end = 1'b1; cyc(1);
        chk("play_state", 32'(state), 2);
        chk("play_time_left", 32'(time_left), 600);
        chk("play_lives", 32'(lives_left), 3);
        chk("play_reset_player", 32'(reset_player), 0);

        tick = 1'b1; cyc(10); tick = 1'b0;
        chk("ten_ticks", 32'(time_left), 590);

        player_at_end = 1'b1; cyc(1);
        chk("done_state", 32'(state), 3);
        chk("done_mazes", 32'(mazes_complete), 1);
        cyc(1);
        chk("regen_state", 32'(state), 1);
        chk("regen_gen_start", 32'(gen_start), 1);
        player_at_end = 1'b0;
        cyc(3);
        chk("stale_gen_end_ignored", 32'(state), 1);
        gen_end = 1'b0; cyc(1);
        gen_end = 1'b1; cyc(1);
        chk("fresh_rise_play", 32'(state), 2);
        chk("level1_limit", 32'(time_left), lim(600, 50, 100, 1));

        big_complete();
        chk("level2_mazes", 32'(mazes_complete), 2);
        chk("level2_limit", 32'(time_left), lim(600, 50, 100, 2));
        for (int i = 0; i < 9; i++) big_complete();
        chk("level11_mazes", 32'(mazes_complete), 11);
        chk("level11_limit", 32'(time_left), lim(600, 50, 100, 11));

        // Short-round instance: lives, game over, restart.
        s_start = 1'b1; cyc(1); s_start = 1'b0;
        chk("s_gen", 32'(s_state), 1);
        s_gen_end = 1'b1; cyc(1);
        chk("s_play_time", 32'(s_time_left), 4);
        s_tick = 1'b1; cyc(4); s_tick = 1'b0;
        chk("s_timeout_lives", 32'(s_lives_left), 1);
        chk("s_timeout_rp", 32'(s_reset_player), 1);
        chk("s_timeout_reload", 32'(s_time_left), lim(4, 1, 1, 0));
        chk("s_timeout_state", 32'(s_state), 2);
        cyc(1);
        chk("s_rp_one_cycle", 32'(s_reset_player), 0);
        s_tick = 1'b1; cyc(4); s_tick = 1'b0;
        chk("s_over_state", 32'(s_state), 4);
        chk("s_over_flag", 32'(s_game_over), 1);
        chk("s_over_lives", 32'(s_lives_left), 0);
        chk("s_over_time", 32'(s_time_left), 0);
        chk("s_over_rp", 32'(s_reset_player), 1);
        s_tick = 1'b1; s_at_end = 1'b1; cyc(2); s_tick = 1'b0; s_at_end = 1'b0;
        chk("s_over_ignores_state", 32'(s_state), 4);
        chk("s_over_ignores_mazes", 32'(s_mazes_complete), 0);
        cyc(1);

        s_start = 1'b1; cyc(1); s_start = 1'b0;
        chk("s_restart_state", 32'(s_state), 1);
        chk("s_restart_lives", 32'(s_lives_left), 2);
        chk("s_restart_over", 32'(s_game_over), 0);
        chk("s_restart_gen_start", 32'(s_gen_start), 1);
        s_gen_end = 1'b0; cyc(1);
        s_gen_end = 1'b1; cyc(1);
        chk("s_replay_state", 32'(s_state), 2);

        // Final tick and exit arrival on the same edge.
        s_tick = 1'b1; cyc(3);
        s_at_end = 1'b1; cyc(1); s_tick = 1'b0;
        chk("s_tie_state", 32'(s_state), 3);
        chk("s_tie_lives", 32'(s_lives_left), 2);
        chk("s_tie_mazes", 32'(s_mazes_complete), 1);
        s_at_end = 1'b0; cyc(1);
        s_gen_end = 1'b0; cyc(1);
        s_gen_end = 1'b1; cyc(1);
        for (int i = 0; i < 4; i++) small_complete();
        chk("s_sat_mazes", 32'(s_mazes_complete), 3);
        chk("s_sat_state", 32'(s_state), 2);
        chk("s_sat_limit", 32'(s_time_left), lim(4, 1, 1, 3));

        // Asynchronous reset in PLAY, away from any clock edge.
        #2; reset = 1'b0; #1;
        chk("arst_state", 32'(s_state), 0);
        chk("arst_time", 32'(s_time_left), 4);
        chk("arst_lives", 32'(s_lives_left), 2);
        chk("arst_mazes", 32'(s_mazes_complete), 0);
        chk("arst_rp", 32'(s_reset_player), 1);
        chk("arst_big_state", 32'(state), 0);
        chk("arst_big_mazes", 32'(mazes_complete), 0);
        chk("arst_big_time", 32'(time_left), 600);
        #10; reset = 1'b1;
        cyc(2);
        chk("post_rst_idle", 32'(state), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
